// File: rtl/delivery_pkg.sv
// rtl/delivery_pkg.sv - grid geometry, scanner state encoding and map indexing
package delivery_pkg;

    localparam int ROWS  = 16;
    localparam int COLS  = 32;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int MAP_W = ROWS * COLS;
    localparam int IW    = $clog2(MAP_W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        SHOW,
        NEXT
    } state_t;

    function automatic logic [IW-1:0] map_index(input logic [RW-1:0] row, input logic [CW-1:0] col);
        return IW'(row) * IW'(COLS) + IW'(col);
    endfunction

endpackage

// File: rtl/delivery_bit_timer.sv
// rtl/delivery_bit_timer.sv - loadable down-counter; done is high in the last cycle of a loaded period
module delivery_bit_timer #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] count;
    logic         active;

    // A load of N makes done rise exactly N cycles later; load wins over an expiring count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            count  <= value - 1'b1;
            active <= 1'b1;
        end else if (active) begin
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign done = active && (count == '0);

endmodule

// File: rtl/delivery_map_scanner.sv
// rtl/delivery_map_scanner.sv - frame-snapshotting row scanner for a shift-register LED matrix
module delivery_map_scanner
    import delivery_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int ROW_HOLD = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [MAP_W-1:0] map_obstacle,
    input  logic [MAP_W-1:0] map_objective,
    input  logic [RW-1:0]    player_position,
    output logic             sclk,
    output logic             sdata_r,
    output logic             sdata_g,
    output logic             sdata_b,
    output logic             latch,
    output logic             oe_n,
    output logic [RW-1:0]    row_sel,
    output logic             busy,
    output logic             frame_done
);

    localparam int MAX_HOLD = (CLK_DIV > ROW_HOLD) ? CLK_DIV : ROW_HOLD;
    localparam int TW       = $clog2(MAX_HOLD + 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    state_t           state;
    logic [RW-1:0]    row;
    logic [CW-1:0]    col;
    logic [RW-1:0]    shadow_pos;
    logic [MAP_W-1:0] shadow_obstacle;
    logic [MAP_W-1:0] shadow_objective;

    logic          timer_load;
    logic          timer_done;
    logic [TW-1:0] timer_value;

    // The timer is reloaded on the same edge the FSM leaves a timed phase, so phases abut exactly.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = TW'(CLK_DIV);
        case (state)
            LOAD:    timer_load = 1'b1;
            SHIFT:   timer_load = timer_done && !(sclk && col == '0);
            LATCH: begin
                timer_load  = 1'b1;
                timer_value = TW'(ROW_HOLD);
            end
            NEXT:    timer_load = (row != LAST_ROW);
            default: timer_load = 1'b0;
        endcase
    end

    delivery_bit_timer #(
        .W(TW)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .load (timer_load),
        .value(timer_value),
        .done (timer_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            row              <= '0;
            col              <= LAST_COL;
            shadow_pos       <= '0;
            shadow_obstacle  <= '0;
            shadow_objective <= '0;
            sclk             <= 1'b0;
            sdata_r          <= 1'b0;
            sdata_g          <= 1'b0;
            sdata_b          <= 1'b0;
            latch            <= 1'b0;
            oe_n             <= 1'b1;
            row_sel          <= '0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    shadow_obstacle  <= map_obstacle;
                    shadow_objective <= map_objective;
                    shadow_pos       <= player_position;
                    row              <= '0;
                    col              <= LAST_COL;
                    sclk             <= 1'b0;
                    // Shadows are being written on this edge, so the first bit comes from the inputs.
                    sdata_r          <= map_obstacle[map_index('0, LAST_COL)];
                    sdata_g          <= map_objective[map_index('0, LAST_COL)];
                    sdata_b          <= 1'b0;
                    frame_done       <= 1'b0;
                    state            <= SHIFT;
                end
                SHIFT: begin
                    if (timer_done) begin
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else if (col == '0) begin
                            sclk    <= 1'b0;
                            sdata_r <= 1'b0;
                            sdata_g <= 1'b0;
                            sdata_b <= 1'b0;
                            latch   <= 1'b1;
                            row_sel <= row;
                            state   <= LATCH;
                        end else begin
                            sclk    <= 1'b0;
                            col     <= col - 1'b1;
                            sdata_r <= shadow_obstacle[map_index(row, col - 1'b1)];
                            sdata_g <= shadow_objective[map_index(row, col - 1'b1)];
                            sdata_b <= (row == shadow_pos) && (col == CW'(1));
                        end
                    end
                end
                LATCH: begin
                    latch <= 1'b0;
                    oe_n  <= 1'b0;
                    state <= SHOW;
                end
                SHOW: begin
                    if (timer_done) begin
                        oe_n       <= 1'b1;
                        frame_done <= (row == LAST_ROW);
                        state      <= NEXT;
                    end
                end
                NEXT: begin
                    frame_done <= 1'b0;
                    if (row != LAST_ROW) begin
                        row     <= row + 1'b1;
                        col     <= LAST_COL;
                        sclk    <= 1'b0;
                        sdata_r <= shadow_obstacle[map_index(row + 1'b1, LAST_COL)];
                        sdata_g <= shadow_objective[map_index(row + 1'b1, LAST_COL)];
                        sdata_b <= 1'b0;
                        state   <= SHIFT;
                    end else if (enable) begin
                        state <= LOAD;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delivery_map_scanner.sv
// tb/tb_delivery_map_scanner.sv - directed self-checking bench for delivery_map_scanner
module tb_delivery_map_scanner;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic [511:0] map_obstacle;
    logic [511:0] map_objective;
    logic [3:0]   player_position;
    logic         sclk, sdata_r, sdata_g, sdata_b, latch, oe_n, busy, frame_done;
    logic [3:0]   row_sel;

    int total = 0;
    int bad   = 0;

    delivery_map_scanner dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .map_obstacle   (map_obstacle),
        .map_objective  (map_objective),
        .player_position(player_position),
        .sclk           (sclk),
        .sdata_r        (sdata_r),
        .sdata_g        (sdata_g),
        .sdata_b        (sdata_b),
        .latch          (latch),
        .oe_n           (oe_n),
        .row_sel        (row_sel),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 clock = ~clock;

    // Capture each row as shifted: bit k of a row word is the k-th bit clocked out (k=0 is col 31).
    logic [31:0] rb_r, rb_g, rb_b;
    logic [5:0]  bitcnt = '0;
    logic        prev_sclk = 1'b0;
    logic [31:0] cap_r [16];
    logic [31:0] cap_g [16];
    logic [31:0] cap_b [16];
    int          latch_count = 0;
    logic [3:0]  last_row = '0;

    always @(negedge clock) begin
        if (!reset) begin
            bitcnt    <= '0;
            prev_sclk <= 1'b0;
        end else begin
            prev_sclk <= sclk;
            if (sclk && !prev_sclk && bitcnt < 6'd32) begin
                rb_r[bitcnt[4:0]] <= sdata_r;
                rb_g[bitcnt[4:0]] <= sdata_g;
                rb_b[bitcnt[4:0]] <= sdata_b;
                bitcnt            <= bitcnt + 6'd1;
            end
            if (latch) begin
                cap_r[row_sel] <= rb_r;
                cap_g[row_sel] <= rb_g;
                cap_b[row_sel] <= rb_b;
                bitcnt         <= '0;
                latch_count    <= latch_count + 1;
                last_row       <= row_sel;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_show(input logic [3:0] r, input string tag);
        int n = 0;
        while (!(oe_n === 1'b0 && row_sel === r) && n < 30000) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(n < 30000), 32'd1);
    endtask

    task automatic wait_fd(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (frame_done !== 1'b1 && n < 30000);
        chk(tag, 32'(n < 30000), 32'd1);
    endtask

    initial begin
        int n;
        int snap;
        int pulses;

        reset           = 1'b0;
        enable          = 1'b1;
        map_obstacle    = '0;
        map_objective   = '0;
        map_obstacle[5] = 1'b1;
        player_position = 4'd3;

        // Reset held with enable high: everything parked
        repeat (3) @(negedge clock);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_r", sdata_r, 1'b0);
        chk("rst_g", sdata_g, 1'b0);
        chk("rst_b", sdata_b, 1'b0);
        chk("rst_latch", latch, 1'b0);
        chk("rst_oe_n", oe_n, 1'b1);
        chk("rst_row_sel", row_sel, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);

        enable = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle_busy", busy, 1'b0);

        // Enable rise to first sclk rise is CLK_DIV+2 cycles
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (sclk !== 1'b1 && n < 20);
        chk("first_sclk_latency", n, 6);
        chk("busy_running", busy, 1'b1);

        // Frame 1: change objective during row 2; it must not appear until frame 2
        wait_show(4'd2, "wait_f1_row2");
        map_objective[40] = 1'b1;
        wait_fd("wait_f1_done", n);
        for (int r = 0; r < 16; r++) begin
            chk($sformatf("f1_r_row%0d", r), cap_r[r], (r == 0) ? 32'h0400_0000 : 32'h0);
            chk($sformatf("f1_g_row%0d", r), cap_g[r], 32'h0);
            chk($sformatf("f1_b_row%0d", r), cap_b[r], (r == 3) ? 32'h8000_0000 : 32'h0);
        end

        // Frame 2: picks up objective bit 40 (row 1, col 8 -> shifted bit 23)
        wait_fd("wait_f2_done", n);
        chk("frame_period", n, 20129);
        chk("f2_g_row1", cap_g[1], 32'h0080_0000);
        chk("f2_g_row2", cap_g[2], 32'h0);
        chk("f2_r_row0", cap_r[0], 32'h0400_0000);
        chk("f2_b_row3", cap_b[3], 32'h8000_0000);

        // Frame 3: drop enable in row 7; rows 8..15 finish, one frame_done, then idle
        wait_show(4'd7, "wait_f3_row7");
        enable = 1'b0;
        snap   = latch_count;
        pulses = 0;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clock);
            if (frame_done === 1'b1) pulses++;
        end
        chk("drop_fd_pulses", pulses, 1);
        chk("drop_rows_scanned", latch_count - snap, 8);
        chk("drop_last_row", last_row, 4'd15);
        chk("drop_busy", busy, 1'b0);
        chk("drop_oe_n", oe_n, 1'b1);

        // Reset in the middle of row 2's shift, then restart must begin at row 0
        enable = 1'b1;
        wait_show(4'd1, "wait_rst_row1");
        n = 0;
        while (oe_n === 1'b0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        repeat (37) @(negedge clock);
        chk("pre_rst_busy", busy, 1'b1);
        chk("pre_rst_row_sel", row_sel, 4'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_sclk", sclk, 1'b0);
        chk("async_rst_oe_n", oe_n, 1'b1);
        chk("async_rst_row_sel", row_sel, 4'd0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_latch", latch, 1'b0);
        chk("async_rst_r", sdata_r, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (latch !== 1'b1 && n < 2000);
        chk("restart_latch_seen", 32'(n < 2000), 32'd1);
        chk("restart_row_sel", row_sel, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
